// File: rtl/gate_request_sequencer_if.sv
// Signal bundle between the badge-scan front end, the occupancy tracker and
// the response consumer. The slave modport is the sequencer's view; the
// master modport is the environment that feeds requests and drives the
// tracker replies.
interface gate_request_sequencer_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Request side
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_mode;
  logic [5:0]    req_userID;

  // Command to the tracker and its reply
  logic [1:0]    mode;
  logic [5:0]    userID;
  logic [1:0]    trk_selectedAreaId;
  logic [5:0]    trk_numberOfInsideUser;
  logic          trk_AlreadyInside;
  logic          trk_NotInside;

  // Response side
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_mode;
  logic [5:0]    rsp_userID;
  logic [1:0]    rsp_areaId;
  logic [5:0]    rsp_count;
  logic [1:0]    rsp_status;

  // Status
  logic [LW-1:0]    fifo_level;
  logic [ERR_W-1:0] err_count;

  modport slave (
    input  req_valid, req_mode, req_userID,
    input  trk_selectedAreaId, trk_numberOfInsideUser, trk_AlreadyInside, trk_NotInside,
    input  rsp_ready,
    output req_ready, mode, userID,
    output rsp_valid, rsp_mode, rsp_userID, rsp_areaId, rsp_count, rsp_status,
    output fifo_level, err_count
  );

  modport master (
    output req_valid, req_mode, req_userID,
    output trk_selectedAreaId, trk_numberOfInsideUser, trk_AlreadyInside, trk_NotInside,
    output rsp_ready,
    input  req_ready, mode, userID,
    input  rsp_valid, rsp_mode, rsp_userID, rsp_areaId, rsp_count, rsp_status,
    input  fifo_level, err_count
  );
endinterface

// File: rtl/gate_request_sequencer.sv
// Queues badge-scan requests, issues each one to the occupancy tracker for a
// single clock, captures the tracker's reply and returns a per-request status.
// Between commands the tracker only ever sees a search, so it never re-runs a
// modifying command on back-to-back clocks.
module gate_request_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  gate_request_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] MODE_SEARCH = 2'b10;
  localparam logic [1:0] MODE_LIST   = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ALREADY = 2'b01;
  localparam logic [1:0] ST_NOTIN   = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  // Request queue: {mode, userID} per entry
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [LW-1:0] level;
  logic          pushEn;
  logic          popEn;
  logic [1:0]    headMode;
  logic [5:0]    headUser;

  // Sequencer state and registered outputs
  state_t           state;
  logic [1:0]       modeReg;
  logic [5:0]       userIdReg;
  logic             rspValid;
  logic [1:0]       rspMode;
  logic [5:0]       rspUserId;
  logic [1:0]       rspAreaId;
  logic [5:0]       rspCount;
  logic [1:0]       rspStatus;
  logic [ERR_W-1:0] errCount;
  logic [ERR_W-1:0] errInc;
  logic [1:0]       captureStatus;

  assign bus.req_ready = (level != LW'(FIFO_DEPTH));
  assign pushEn        = bus.req_valid && bus.req_ready;
  assign popEn         = (state == IDLE) && (level != '0);
  assign {headMode, headUser} = fifoMem[rdPtr];

  // Saturating increment of the error counter
  assign errInc = (&errCount) ? errCount : errCount + 1'b1;

  // Tracker flags to status; AlreadyInside wins over NotInside
  always_comb begin
    captureStatus = ST_OK;
    if (bus.trk_AlreadyInside) begin
      captureStatus = ST_ALREADY;
    end else if (bus.trk_NotInside) begin
      captureStatus = ST_NOTIN;
    end
  end

  // Request storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (pushEn) begin
      fifoMem[wrPtr] <= {bus.req_mode, bus.req_userID};
    end
  end

  // Queue pointers and occupancy; pops are taken only from IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Issue / capture / respond sequencer with registered tracker command and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      modeReg   <= MODE_SEARCH;
      userIdReg <= '0;
      rspValid  <= 1'b0;
      rspMode   <= '0;
      rspUserId <= '0;
      rspAreaId <= '0;
      rspCount  <= '0;
      rspStatus <= '0;
      errCount  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (popEn) begin
            rspMode   <= headMode;
            rspUserId <= headUser;
            if (headMode == MODE_LIST) begin
              // List is never forwarded: answer ILLEGAL without touching the tracker
              rspStatus <= ST_ILLEGAL;
              rspAreaId <= headUser[5:4];
              rspCount  <= '0;
              rspValid  <= 1'b1;
              errCount  <= errInc;
              state     <= RESP;
            end else begin
              modeReg   <= headMode;
              userIdReg <= headUser;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          modeReg <= MODE_SEARCH;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          rspAreaId <= bus.trk_selectedAreaId;
          rspCount  <= bus.trk_numberOfInsideUser;
          rspStatus <= captureStatus;
          rspValid  <= 1'b1;
          if (captureStatus != ST_OK) begin
            errCount <= errInc;
          end
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mode       = modeReg;
  assign bus.userID     = userIdReg;
  assign bus.rsp_valid  = rspValid;
  assign bus.rsp_mode   = rspMode;
  assign bus.rsp_userID = rspUserId;
  assign bus.rsp_areaId = rspAreaId;
  assign bus.rsp_count  = rspCount;
  assign bus.rsp_status = rspStatus;
  assign bus.fifo_level = level;
  assign bus.err_count  = errCount;
endmodule

// File: tb/tb_gate_request_sequencer.sv
// Bench for gate_request_sequencer: a behavioural occupancy tracker answers
// the issued commands, a list-of-occupants reference predicts each response
// at push time, and a monitor pops and compares when a response is taken.
module tb_gate_request_sequencer;
  localparam int DEPTH   = 4;
  localparam int EW      = 3;
  localparam int MAX_ERR = (1 << EW) - 1;

  logic clk;
  logic rst_n;

  gate_request_sequencer_if #(.FIFO_DEPTH(DEPTH), .ERR_W(EW)) bus ();

  gate_request_sequencer #(.FIFO_DEPTH(DEPTH), .ERR_W(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Tracker stand-in: one occupancy bitmap per area, registered replies
  logic [15:0] occ [4];
  initial foreach (occ[i]) occ[i] = '0;

  always @(posedge clk) begin
    logic [1:0] a;
    logic [3:0] u;
    logic       hit;
    a   = bus.userID[5:4];
    u   = bus.userID[3:0];
    hit = occ[a][u];
    bus.trk_AlreadyInside <= 1'b0;
    bus.trk_NotInside     <= 1'b0;
    case (bus.mode)
      2'b01: if (hit) bus.trk_AlreadyInside <= 1'b1; else occ[a][u] = 1'b1;
      2'b00: if (!hit) bus.trk_NotInside <= 1'b1; else occ[a][u] = 1'b0;
      default: ;
    endcase
    bus.trk_selectedAreaId     <= a;
    bus.trk_numberOfInsideUser <= 6'($countones(occ[a]));
  end

  // Reference: who is inside, as a plain list of full user IDs
  typedef struct packed {
    logic [1:0] mode;
    logic [5:0] uid;
    logic [1:0] area;
    logic [5:0] count;
    logic [1:0] status;
  } exp_t;

  logic [5:0] occupants[$];
  exp_t       sbq[$];
  int         errSeen = 0;

  function automatic exp_t predict(input logic [1:0] m, input logic [5:0] u);
    exp_t e;
    int   idx;
    int   cnt;
    idx = -1;
    foreach (occupants[i]) if (occupants[i] == u) idx = i;
    e.mode   = m;
    e.uid    = u;
    e.area   = u[5:4];
    e.status = 2'b00;
    case (m)
      2'b01: if (idx >= 0) e.status = 2'b01; else occupants.push_back(u);
      2'b00: if (idx < 0) e.status = 2'b10; else occupants.delete(idx);
      2'b11: e.status = 2'b11;
      default: ;
    endcase
    cnt = 0;
    foreach (occupants[i]) if (occupants[i][5:4] == u[5:4]) cnt++;
    e.count = (m == 2'b11) ? 6'd0 : 6'(cnt);
    return e;
  endfunction

  // Monitor: compare every accepted response against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    int   expErr;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_rsp", 32'(bus.rsp_userID), 32'hFFFF);
      end else begin
        e = sbq.pop_front();
        if (e.status != 2'b00) errSeen++;
        expErr = (errSeen > MAX_ERR) ? MAX_ERR : errSeen;
        $display("rsp mode=%b uid=%h area=%0d count=%0d status=%b err=%0d",
                 bus.rsp_mode, bus.rsp_userID, bus.rsp_areaId, bus.rsp_count,
                 bus.rsp_status, bus.err_count);
        check("rsp_mode",   32'(bus.rsp_mode),   32'(e.mode));
        check("rsp_userID", 32'(bus.rsp_userID), 32'(e.uid));
        check("rsp_areaId", 32'(bus.rsp_areaId), 32'(e.area));
        check("rsp_count",  32'(bus.rsp_count),  32'(e.count));
        check("rsp_status", 32'(bus.rsp_status), 32'(e.status));
        check("err_count",  32'(bus.err_count),  32'(expErr));
      end
    end
  end

  // Command watcher: a modifying command lasts one cycle and list never reaches the tracker
  logic [1:0] prevMode;
  int         nonSearchCycles = 0;
  always @(negedge clk) begin
    if (rst_n && bus.mode != 2'b10) begin
      nonSearchCycles++;
      check("mode_not_list",  32'(bus.mode == 2'b11), 32'd0);
      check("mode_one_cycle", 32'(prevMode), 32'd2);
    end
    prevMode = bus.mode;
  end

  // Random consumer back-pressure
  bit randReady = 0;
  always @(posedge clk) begin
    if (randReady) begin
      #1;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [1:0] m, input logic [5:0] u, input int maxWait, output bit ok);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_mode   = m;
    bus.req_userID = u;
    ok = 0;
    for (int w = 0; w <= maxWait; w++) begin
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      $display("req mode=%b uid=%h", m, u);
      sbq.push_back(predict(m, u));
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic sendChecked(input logic [1:0] m, input logic [5:0] u);
    bit ok;
    send(m, u, 300, ok);
    check("req_accepted", 32'(ok), 32'd1);
  endtask

  task automatic latency(input int expLat, input string name);
    int lat;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
    end
    check(name, 32'(lat), 32'(expLat));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sbq.size() != 0 || bus.rsp_valid || bus.fifo_level != 0) && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_done", 32'(w < 2000), 32'd1);
  endtask

  initial begin
    bit ok;
    int snap;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_mode   = 2'b00;
    bus.req_userID = 6'd0;
    bus.rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_mode",       32'(bus.mode),       32'd2);
    check("rst_userID",     32'(bus.userID),     32'd0);
    check("rst_err_count",  32'(bus.err_count),  32'd0);
    check("rst_rsp_status", 32'(bus.rsp_status), 32'd0);
    check("rst_rsp_count",  32'(bus.rsp_count),  32'd0);

    // First entrance: three-edge latency
    sendChecked(2'b01, 6'h01);
    latency(3, "lat_entrance");
    drain();

    // Same entrance twice back to back: second reads AlreadyInside
    sendChecked(2'b01, 6'h03);
    sendChecked(2'b01, 6'h03);
    drain();
    check("err_after_dup", 32'(bus.err_count), 32'd1);

    // Exit of a user absent from area 3, which holds only user 2
    sendChecked(2'b01, 6'h32);
    sendChecked(2'b00, 6'h35);
    drain();
    check("err_after_exit", 32'(bus.err_count), 32'd2);

    // List request: answered locally after one edge
    sendChecked(2'b11, 6'h14);
    latency(1, "lat_list");
    drain();
    check("err_after_list", 32'(bus.err_count), 32'd3);

    // Consumer stalled: one request parked in RESP, four fill the queue
    bus.rsp_ready = 1'b0;
    sendChecked(2'b01, 6'h25);
    sendChecked(2'b01, 6'h26);
    sendChecked(2'b10, 6'h20);
    sendChecked(2'b11, 6'h3F);
    sendChecked(2'b00, 6'h25);
    check("stall_level",     32'(bus.fifo_level), 32'd4);
    check("stall_req_ready", 32'(bus.req_ready),  32'd0);
    send(2'b01, 6'h27, 0, ok);
    check("full_rejects", 32'(ok), 32'd0);
    check("stall_rsp_held", 32'(bus.rsp_userID), 32'h25);
    bus.rsp_ready = 1'b1;
    drain();

    // Reset while in CAPTURE with two entries queued
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_mode   = 2'b10;
    bus.req_userID = 6'h11;
    @(posedge clk);
    #1;
    bus.req_mode   = 2'b01;
    bus.req_userID = 6'h3A;
    @(posedge clk);
    #1;
    bus.req_userID = 6'h3B;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rst_setup_level", 32'(bus.fifo_level), 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sbq.delete();
    errSeen = 0;
    check("mid_rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check("mid_rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    check("mid_rst_mode",       32'(bus.mode),       32'd2);
    check("mid_rst_err_count",  32'(bus.err_count),  32'd0);
    check("mid_rst_req_ready",  32'(bus.req_ready),  32'd1);
    rst_n = 1'b1;
    snap = nonSearchCycles;
    repeat (12) @(posedge clk);
    #1;
    check("no_cmd_after_rst", 32'(nonSearchCycles - snap), 32'd0);
    check("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);

    // Randomized traffic with random back-pressure
    randReady = 1;
    for (int t = 0; t < 120; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      sendChecked(2'($urandom_range(0, 3)), {2'($urandom_range(0, 3)), 4'($urandom_range(0, 3))});
    end
    randReady = 0;
    @(posedge clk);
    #2;
    bus.rsp_ready = 1'b1;
    drain();
    check("final_err_count", 32'(bus.err_count),
          32'((errSeen > MAX_ERR) ? MAX_ERR : errSeen));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
